// File: rtl/ad1939_pkg.sv
// rtl/ad1939_pkg.sv - shared constants and FSM state type for the AD1939 ADC I2S receiver
package ad1939_pkg;

    localparam int DATA_W_DEF      = 24;
    localparam int SLOT_W_DEF      = 32;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ad1939_sync_edge_det.sv
// rtl/ad1939_sync_edge_det.sv - multi-flop synchroniser with optional registered rising-edge pulse
module sync_edge_det #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    // STAGES must be at least 2
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;
            logic rise_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prev_q <= 1'b0;
                    rise_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[STAGES-1];
                    rise_q <= sync_q[STAGES-1] & ~prev_q;
                end
            end

            assign rise = rise_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ad1939_adc_i2s_rx.sv
// rtl/ad1939_adc_i2s_rx.sv - oversampling I2S deserialiser for the AD1939 ADC port with Avalon-ST output
module ad1939_adc_i2s_rx
    import ad1939_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SLOT_W      = SLOT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              abclk,
    input  logic              alrclk,
    input  logic              asdata,
    output logic [DATA_W-1:0] ast_data,
    output logic              ast_channel,
    output logic              ast_valid,
    input  logic              ast_ready,
    output logic              overrun,
    output logic              frame_err,
    input  logic              clear_err
);

    localparam int CNT_W = $clog2(SLOT_W + 2);
    localparam int BIT_W = $clog2(DATA_W + 1);

    logic bit_strobe;
    logic lr_sync;
    logic sd_sync;
    logic unused_abclk_lvl;
    logic unused_lr_rise;
    logic unused_sd_rise;

    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_abclk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (abclk),
        .dout    (unused_abclk_lvl),
        .rise    (bit_strobe)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_alrclk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (alrclk),
        .dout    (lr_sync),
        .rise    (unused_lr_rise)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_asdata (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (asdata),
        .dout    (sd_sync),
        .rise    (unused_sd_rise)
    );

    rx_state_t         state_q, state_d;
    logic              lr_q, lr_d;
    logic              primed_q, primed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bits_q, bits_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              chan_q, chan_d;
    logic [DATA_W-1:0] shift_word;
    logic              lr_change;
    logic              load;
    logic              frame_evt;
    logic              overrun_evt;

    // primed blocks a bogus "change" against the reset value of lr_q on the first strobe
    assign lr_change  = primed_q && (lr_sync != lr_q);
    assign shift_word = {shreg_q[DATA_W-2:0], sd_sync};

    always_comb begin
        state_d   = state_q;
        lr_d      = lr_q;
        primed_d  = primed_q;
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        shreg_d   = shreg_q;
        chan_d    = chan_q;
        load      = 1'b0;
        frame_evt = 1'b0;

        if (bit_strobe) begin
            lr_d     = lr_sync;
            primed_d = 1'b1;

            if (lr_change) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_W'(SLOT_W + 1)) begin
                cnt_d = cnt_q + 1'b1;
            end

            // The strobe that reveals an alrclk change is the I2S delay bit; the MSB follows
            unique case (state_q)
                IDLE: begin
                    if (lr_change) begin
                        state_d = DELAY;
                        chan_d  = lr_sync;
                    end
                end
                DELAY: begin
                    if (lr_change) begin
                        frame_evt = 1'b1;
                        chan_d    = lr_sync;
                    end else begin
                        shreg_d = shift_word;
                        bits_d  = BIT_W'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (lr_change) begin
                        frame_evt = 1'b1;
                        chan_d    = lr_sync;
                        state_d   = DELAY;
                    end else begin
                        shreg_d = shift_word;
                        bits_d  = bits_q + 1'b1;
                        if (bits_q == BIT_W'(DATA_W - 1)) begin
                            load    = 1'b1;
                            state_d = PAD;
                        end
                    end
                end
                PAD: begin
                    if (lr_change) begin
                        state_d = DELAY;
                        chan_d  = lr_sync;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (state_q != IDLE && !lr_change && cnt_q == CNT_W'(SLOT_W)) begin
                frame_evt = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lr_q     <= 1'b0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            bits_q   <= '0;
            shreg_q  <= '0;
            chan_q   <= CH_LEFT;
        end else begin
            state_q  <= state_d;
            lr_q     <= lr_d;
            primed_q <= primed_d;
            cnt_q    <= cnt_d;
            bits_q   <= bits_d;
            shreg_q  <= shreg_d;
            chan_q   <= chan_d;
        end
    end

    assign overrun_evt = load && ast_valid && !ast_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ast_data    <= '0;
            ast_channel <= CH_LEFT;
            ast_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (load) begin
                ast_data    <= shift_word;
                ast_channel <= chan_q;
                ast_valid   <= 1'b1;
            end else if (ast_valid && ast_ready) begin
                ast_valid <= 1'b0;
            end

            if (overrun_evt) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end

            if (frame_evt) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ad1939_adc_i2s_rx.sv
// tb/tb_ad1939_adc_i2s_rx.sv - directed self-checking bench for ad1939_adc_i2s_rx
module tb_ad1939_adc_i2s_rx;

    localparam int DATA_W      = 24;
    localparam int SLOT_W      = 32;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 16;

    logic              clk;
    logic              reset_n;
    logic              abclk;
    logic              alrclk;
    logic              asdata;
    logic [DATA_W-1:0] ast_data;
    logic              ast_channel;
    logic              ast_valid;
    logic              ast_ready;
    logic              overrun;
    logic              frame_err;
    logic              clear_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lsb_cyc = 0;

    logic [24:0] got_q[$];
    int          lat_q[$];
    logic        prev_valid = 1'b0;

    ad1939_adc_i2s_rx #(
        .DATA_W      (DATA_W),
        .SLOT_W      (SLOT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .abclk       (abclk),
        .alrclk      (alrclk),
        .asdata      (asdata),
        .ast_data    (ast_data),
        .ast_channel (ast_channel),
        .ast_valid   (ast_valid),
        .ast_ready   (ast_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .clear_err   (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ast_valid && ast_ready) got_q.push_back({ast_channel, ast_data});
        if (ast_valid && !prev_valid) lat_q.push_back(cyc - lsb_cyc);
        prev_valid = ast_valid;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic lr, input logic b, input bit set_lr,
                            input bit is_lsb, input bit pulse);
        @(negedge clk);
        abclk = 1'b0;
        if (set_lr) alrclk = lr;
        asdata = b;
        repeat (HALF - 1) @(negedge clk);
        @(negedge clk);
        abclk = 1'b1;
        if (is_lsb) lsb_cyc = cyc;
        for (int c = 1; c <= HALF; c++) begin
            @(posedge clk);
            if (pulse && c == SYNC_STAGES + 1) begin
                #1 ast_ready = 1'b1;
            end else if (pulse && c == SYNC_STAGES + 2) begin
                #1 ast_ready = 1'b0;
            end
        end
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] data, input int nbits, input bit pulse);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = (i >= 1 && i <= 24) ? data[24 - i] : 1'b0;
            send_bit(lr, b, i == 0, i == 24, pulse && i == 24);
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (ast_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ast_valid); end
        n_tests++; if (ast_data !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", ast_data); end
        n_tests++; if (ast_channel !== 1'b0) begin n_fail++; $display("FAIL reset_channel: got %b want 0", ast_channel); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset_n = 1'b1;
        send_slot(1'b1, 24'h0, 32, 1'b0);
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_no_partial: got %0d words want 0", got_q.size()); end
    endtask

    task automatic test_basic_stream();
        logic [24:0] exp[$];
        got_q.delete();
        ast_ready = 1'b1;
        repeat (2) begin
            send_slot(1'b0, 24'hA5A5A5, 32, 1'b0);
            send_slot(1'b1, 24'h123456, 32, 1'b0);
        end
        exp = '{25'h0A5A5A5, 25'h1123456, 25'h0A5A5A5, 25'h1123456};
        n_tests++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp.size()); end
        foreach (exp[i]) if (i < got_q.size()) begin
            n_tests++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], exp[i]); end
        end
        n_tests++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got ovr=%b ferr=%b want 0 0", overrun, frame_err); end
    endtask

    task automatic test_full_scale();
        logic [24:0] exp[$];
        got_q.delete();
        lat_q.delete();
        send_slot(1'b0, 24'h800000, 32, 1'b0);
        send_slot(1'b1, 24'h7FFFFF, 32, 1'b0);
        exp = '{25'h0800000, 25'h17FFFFF};
        n_tests++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL fs_count: got %0d want %0d", got_q.size(), exp.size()); end
        foreach (exp[i]) if (i < got_q.size()) begin
            n_tests++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL fs_word%0d: got %h want %h", i, got_q[i], exp[i]); end
        end
        n_tests++; if (lat_q.size() != 2) begin n_fail++; $display("FAIL fs_lat_count: got %0d want 2", lat_q.size()); end
        foreach (lat_q[i]) begin
            n_tests++; if (lat_q[i] != SYNC_STAGES + 2) begin n_fail++; $display("FAIL fs_latency%0d: got %0d want %0d", i, lat_q[i], SYNC_STAGES + 2); end
        end
    endtask

    task automatic test_overrun();
        got_q.delete();
        ast_ready = 1'b0;
        send_slot(1'b0, 24'h0ABCDE, 32, 1'b0);
        send_slot(1'b1, 24'h654321, 32, 1'b0);
        n_tests++; if (ast_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", ast_valid); end
        n_tests++; if ({ast_channel, ast_data} !== 25'h1654321) begin n_fail++; $display("FAIL ovr_data: got %h want 1654321", {ast_channel, ast_data}); end
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ovr_ferr: got %b want 0", frame_err); end
        pulse_clear();
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        n_tests++; if (ast_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_kept: got %b want 1", ast_valid); end
        @(posedge clk);
        #1 ast_ready = 1'b1;
        @(posedge clk);
        #1 ast_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (got_q.size() != 1 || got_q[0] !== 25'h1654321) begin n_fail++; $display("FAIL ovr_drain: got %0d words first %h want 1 word 1654321", got_q.size(), got_q.size() ? got_q[0] : 25'h0); end
        n_tests++; if (ast_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b want 0", ast_valid); end
    endtask

    task automatic test_accept_on_load();
        got_q.delete();
        lat_q.delete();
        ast_ready = 1'b0;
        send_slot(1'b0, 24'h5A5A5A, 32, 1'b0);
        send_slot(1'b1, 24'hC3C3C3, 32, 1'b1);
        n_tests++; if (got_q.size() != 1 || got_q[0] !== 25'h05A5A5A) begin n_fail++; $display("FAIL aol_accepted: got %0d words first %h want 1 word 05A5A5A", got_q.size(), got_q.size() ? got_q[0] : 25'h0); end
        n_tests++; if (ast_valid !== 1'b1 || {ast_channel, ast_data} !== 25'h1C3C3C3) begin n_fail++; $display("FAIL aol_pending: got v=%b %h want v=1 1C3C3C3", ast_valid, {ast_channel, ast_data}); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL aol_overrun: got %b want 0", overrun); end
        n_tests++; if (lat_q.size() != 1) begin n_fail++; $display("FAIL aol_valid_gap: got %0d valid rises want 1", lat_q.size()); end
        @(posedge clk);
        #1 ast_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (ast_valid !== 1'b0) begin n_fail++; $display("FAIL aol_drain: got %b want 0", ast_valid); end
    endtask

    task automatic test_short_slot();
        logic [24:0] exp[$];
        got_q.delete();
        ast_ready = 1'b1;
        send_slot(1'b0, 24'hABCDEF, 11, 1'b0);
        send_slot(1'b1, 24'h13579B, 32, 1'b0);
        send_slot(1'b0, 24'h2468AC, 32, 1'b0);
        exp = '{25'h113579B, 25'h02468AC};
        n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_ferr: got %b want 1", frame_err); end
        n_tests++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL short_count: got %0d want %0d", got_q.size(), exp.size()); end
        foreach (exp[i]) if (i < got_q.size()) begin
            n_tests++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL short_word%0d: got %h want %h", i, got_q[i], exp[i]); end
        end
        pulse_clear();
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL short_clear: got %b want 0", frame_err); end
    endtask

    task automatic test_long_slot();
        logic [24:0] exp[$];
        got_q.delete();
        send_slot(1'b1, 24'h0F0F0F, SLOT_W + 2, 1'b0);
        n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL long_ferr: got %b want 1", frame_err); end
        send_slot(1'b0, 24'h3C3C3C, 32, 1'b0);
        exp = '{25'h10F0F0F, 25'h03C3C3C};
        n_tests++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL long_count: got %0d want %0d", got_q.size(), exp.size()); end
        foreach (exp[i]) if (i < got_q.size()) begin
            n_tests++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL long_word%0d: got %h want %h", i, got_q[i], exp[i]); end
        end
        pulse_clear();
    endtask

    task automatic test_reset_mid_slot();
        logic [24:0] exp[$];
        got_q.delete();
        send_slot(1'b1, 24'h777777, 12, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++; if (ast_valid !== 1'b0 || ast_data !== 24'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got v=%b d=%h want v=0 d=000000", ast_valid, ast_data); end
        reset_n = 1'b1;
        send_slot(1'b1, 24'h555555, 20, 1'b0);
        send_slot(1'b0, 24'h222222, 32, 1'b0);
        send_slot(1'b1, 24'h333333, 32, 1'b0);
        exp = '{25'h0222222, 25'h1333333};
        n_tests++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", got_q.size(), exp.size()); end
        foreach (exp[i]) if (i < got_q.size()) begin
            n_tests++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL mid_word%0d: got %h want %h", i, got_q[i], exp[i]); end
        end
        n_tests++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got ovr=%b ferr=%b want 0 0", overrun, frame_err); end
    endtask

    initial begin
        abclk     = 1'b0;
        alrclk    = 1'b1;
        asdata    = 1'b0;
        ast_ready = 1'b1;
        clear_err = 1'b0;
        reset_n   = 1'b0;
        test_reset();
        test_basic_stream();
        test_full_scale();
        test_overrun();
        test_accept_on_load();
        test_short_slot();
        test_long_slot();
        test_reset_mid_slot();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
